// File: rtl/operand_feeder_if.sv
// Serial-in / parallel-out handshake bundle for operand_feeder.
// out_sum exists only when FEEDER_CHECKSUM_EN is defined.
interface operand_feeder_if #(
  parameter int WIDTH = 11,
  parameter int LANES = 8
);
  logic                   in_valid;
  logic                   in_ready;
  logic [WIDTH-1:0]       in_data;
  logic                   flush;
  logic                   out_valid;
  logic                   out_ready;
  logic [LANES*WIDTH-1:0] out_data;
  logic [3:0]             out_lanes;
`ifdef FEEDER_CHECKSUM_EN
  logic [WIDTH+2:0]       out_sum;

  modport master (
    output in_valid, in_data, flush, out_ready,
    input  in_ready, out_valid, out_data, out_lanes, out_sum
  );
  modport slave (
    input  in_valid, in_data, flush, out_ready,
    output in_ready, out_valid, out_data, out_lanes, out_sum
  );
`else
  modport master (
    output in_valid, in_data, flush, out_ready,
    input  in_ready, out_valid, out_data, out_lanes
  );
  modport slave (
    input  in_valid, in_data, flush, out_ready,
    output in_ready, out_valid, out_data, out_lanes
  );
`endif
endinterface

// File: rtl/operand_feeder.sv
// Gathers serial operands into 8-lane groups (fill bank + output bank), with flush-to-pad.
// Optional feature macro: FEEDER_CHECKSUM_EN adds registered out_sum of the output lanes.
module operand_feeder #(
  parameter int WIDTH = 11,
  parameter int LANES = 8
) (
  input logic            clk,
  input logic            rst_n,
  operand_feeder_if.slave bus
);

  typedef enum logic {FILL = 1'b0, PEND = 1'b1} state_t;

  state_t                 state_q, state_d;
  logic [2:0]             cnt_q, cnt_d;
  logic [WIDTH-1:0]       fill_q [LANES];
  logic [WIDTH-1:0]       fill_d [LANES];
  logic [3:0]             pend_lanes_q, pend_lanes_d;
  logic                   out_valid_q, out_valid_d;
  logic [LANES*WIDTH-1:0] out_data_q, out_data_d;
  logic [3:0]             out_lanes_q, out_lanes_d;

  logic                   accept;
  logic                   out_free;
  logic                   close;
  logic [3:0]             n_lanes;
  logic [LANES*WIDTH-1:0] group;
  logic [LANES*WIDTH-1:0] fill_flat;

  assign bus.in_ready  = (state_q == FILL);
  assign accept        = bus.in_valid && bus.in_ready;
  assign out_free      = !out_valid_q || bus.out_ready;
  assign n_lanes       = {1'b0, cnt_q} + {3'b000, accept};
  // A group closes on the 8th operand, or on flush when it would hold at least one lane.
  assign close         = (state_q == FILL) &&
                         ((accept && cnt_q == 3'd7) ||
                          (bus.flush && (cnt_q != 3'd0 || accept)));

  // Candidate group: stored lanes, then the operand arriving this cycle, zero above.
  always_comb begin
    group = '0;
    for (int k = 0; k < LANES; k++) begin
      if (k < int'(cnt_q))
        group[k*WIDTH +: WIDTH] = fill_q[k];
      else if (k == int'(cnt_q) && accept)
        group[k*WIDTH +: WIDTH] = bus.in_data;
    end
  end

  always_comb begin
    fill_flat = '0;
    for (int k = 0; k < LANES; k++)
      fill_flat[k*WIDTH +: WIDTH] = fill_q[k];
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL:    if (close && !out_free) state_d = PEND;
      PEND:    if (out_free)           state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  always_comb begin
    cnt_d        = cnt_q;
    fill_d       = fill_q;
    pend_lanes_d = pend_lanes_q;
    out_valid_d  = out_valid_q && !bus.out_ready;
    out_data_d   = out_data_q;
    out_lanes_d  = out_lanes_q;
    if (state_q == PEND) begin
      if (out_free) begin
        out_valid_d = 1'b1;
        out_data_d  = fill_flat;
        out_lanes_d = pend_lanes_q;
        cnt_d       = 3'd0;
      end
    end else if (close) begin
      cnt_d = 3'd0;
      if (out_free) begin
        out_valid_d = 1'b1;
        out_data_d  = group;
        out_lanes_d = n_lanes;
      end else begin
        // Park the already padded group in the fill bank until the output bank frees.
        for (int k = 0; k < LANES; k++)
          fill_d[k] = group[k*WIDTH +: WIDTH];
        pend_lanes_d = n_lanes;
      end
    end else if (accept) begin
      fill_d[cnt_q] = bus.in_data;
      cnt_d         = cnt_q + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= FILL;
      cnt_q        <= 3'd0;
      pend_lanes_q <= 4'd0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_lanes_q  <= 4'd0;
      for (int k = 0; k < LANES; k++)
        fill_q[k] <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pend_lanes_q <= pend_lanes_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_lanes_q  <= out_lanes_d;
      fill_q       <= fill_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_lanes = out_lanes_q;

`ifdef FEEDER_CHECKSUM_EN
  logic [WIDTH+2:0] out_sum_q, out_sum_d;

  function automatic logic [WIDTH+2:0] lane_sum(input logic [LANES*WIDTH-1:0] d);
    logic [WIDTH+2:0] s;
    s = '0;
    for (int k = 0; k < LANES; k++)
      s = s + {3'b000, d[k*WIDTH +: WIDTH]};
    return s;
  endfunction

  assign out_sum_d = lane_sum(out_data_d);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out_sum_q <= '0;
    else        out_sum_q <= out_sum_d;
  end

  assign bus.out_sum = out_sum_q;
`endif

endmodule

// File: tb/tb_operand_feeder.sv
// Directed bench for operand_feeder: stimulus pushes hand-computed groups, a monitor pops on each consumed group.
module tb_operand_feeder;

  localparam int W = 11;
  localparam int L = 8;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   ngroups = 0;

  typedef struct {
    logic [L*W-1:0] data;
    logic [3:0]     lanes;
    logic [W+2:0]   sum;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  operand_feeder_if #(.WIDTH(W), .LANES(L)) bus ();

  operand_feeder #(.WIDTH(W), .LANES(L)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [L*W-1:0] mk(input logic [W-1:0] l0, l1, l2, l3, l4, l5, l6, l7);
    return {l7, l6, l5, l4, l3, l2, l1, l0};
  endfunction

  task automatic push_exp(input logic [L*W-1:0] d, input int n, input int s);
    exp_t x;
    x.data  = d;
    x.lanes = 4'(n);
    x.sum   = (W+3)'(s);
    sb.push_back(x);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [W-1:0] d, input bit fl);
    int n;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.flush    = fl;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got in_ready=0 for %0d cycles expected 1", n);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
  endtask

  task automatic do_flush();
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
  endtask

  // Monitor: every consumed group must match the oldest expected one.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_group: got data %0h expected no group", bus.out_data);
      end else begin
        e = sb.pop_front();
        chk("grp_data", 128'(bus.out_data), 128'(e.data));
        chk("grp_lanes", 128'(bus.out_lanes), 128'(e.lanes));
`ifdef FEEDER_CHECKSUM_EN
        chk("grp_sum", 128'(bus.out_sum), 128'(e.sum));
`endif
        ngroups++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int g0;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.flush    = 1'b0;
    bus.out_ready = 1'b0;
    idle(3);
    chk("rst_in_ready", 128'(bus.in_ready), 128'(1));
    chk("rst_out_valid", 128'(bus.out_valid), 128'(0));
    chk("rst_out_data", 128'(bus.out_data), 128'(0));
    chk("rst_out_lanes", 128'(bus.out_lanes), 128'(0));
`ifdef FEEDER_CHECKSUM_EN
    chk("rst_out_sum", 128'(bus.out_sum), 128'(0));
`endif
    rst_n = 1'b1;
    idle(1);

    // Full group, back to back, consumer always ready
    bus.out_ready = 1'b1;
    push_exp(mk(1, 2, 3, 4, 5, 6, 7, 8), 8, 36);
    t0 = cyc;
    for (int i = 1; i <= 8; i++) send(W'(i), 1'b0);
    chk("b2b_cycles", 128'(cyc - t0), 128'(8));
    chk("latency_valid", 128'(bus.out_valid), 128'(1));
    idle(2);
    chk("valid_clears", 128'(bus.out_valid), 128'(0));

    // Backpressure: second group parks in PEND
    bus.out_ready = 1'b0;
    push_exp(mk(10, 11, 12, 13, 14, 15, 16, 17), 8, 108);
    push_exp(mk(18, 19, 20, 21, 22, 23, 24, 25), 8, 172);
    for (int i = 0; i < 16; i++) send(W'(10 + i), 1'b0);
    chk("pend_in_ready", 128'(bus.in_ready), 128'(0));
    chk("hold_data_a", 128'(bus.out_data), 128'(mk(10, 11, 12, 13, 14, 15, 16, 17)));
    idle(3);
    chk("hold_data_b", 128'(bus.out_data), 128'(mk(10, 11, 12, 13, 14, 15, 16, 17)));
    chk("hold_valid", 128'(bus.out_valid), 128'(1));
    bus.out_ready = 1'b1;
    idle(1);
    chk("pend_release_ready", 128'(bus.in_ready), 128'(1));
    chk("pend_release_data", 128'(bus.out_data), 128'(mk(18, 19, 20, 21, 22, 23, 24, 25)));
    chk("pend_release_valid", 128'(bus.out_valid), 128'(1));
    idle(2);

    // Flush alone, then flush coincident with the last operand
    push_exp(mk(5, 6, 7, 0, 0, 0, 0, 0), 3, 18);
    send(W'(5), 1'b0);
    send(W'(6), 1'b0);
    send(W'(7), 1'b0);
    do_flush();
    chk("flush_lanes", 128'(bus.out_lanes), 128'(3));
    push_exp(mk(5, 6, 7, 0, 0, 0, 0, 0), 3, 18);
    send(W'(5), 1'b0);
    send(W'(6), 1'b0);
    send(W'(7), 1'b1);
    chk("flush_coinc_lanes", 128'(bus.out_lanes), 128'(3));
    idle(3);

    // Ignored flushes: empty fill bank, and while in PEND
    g0 = ngroups;
    do_flush();
    idle(3);
    chk("flush_empty_valid", 128'(bus.out_valid), 128'(0));
    chk("flush_empty_groups", 128'(ngroups), 128'(g0));
    bus.out_ready = 1'b0;
    push_exp(mk(30, 31, 32, 33, 34, 35, 36, 37), 8, 268);
    push_exp(mk(38, 39, 40, 41, 42, 43, 44, 45), 8, 332);
    for (int i = 0; i < 16; i++) send(W'(30 + i), 1'b0);
    do_flush();
    idle(2);
    chk("flush_pend_ready", 128'(bus.in_ready), 128'(0));
    chk("flush_pend_lanes", 128'(bus.out_lanes), 128'(8));
    bus.out_ready = 1'b1;
    idle(3);
    push_exp(mk(50, 51, 52, 53, 54, 55, 56, 57), 8, 428);
    for (int i = 0; i < 8; i++) send(W'(50 + i), 1'b0);
    idle(3);
    chk("flush_pend_groups", 128'(ngroups), 128'(g0 + 3));

    // Reset with a group held and a partial group buffered
    bus.out_ready = 1'b0;
    for (int i = 0; i < 12; i++) send(W'(60 + i), 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 128'(bus.out_valid), 128'(0));
    chk("async_rst_data", 128'(bus.out_data), 128'(0));
    chk("async_rst_lanes", 128'(bus.out_lanes), 128'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("post_rst_ready", 128'(bus.in_ready), 128'(1));
    bus.out_ready = 1'b1;
    push_exp(mk(11'h7FF, 11'h7FF, 11'h7FF, 11'h7FF, 11'h7FF, 11'h7FF, 11'h7FF, 11'h7FF), 8, 'h3FF8);
    for (int i = 0; i < 8; i++) send(11'h7FF, 1'b0);
    idle(3);

    chk("scoreboard_empty", 128'(sb.size()), 128'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
